// File: rtl/mux_pipe_if.sv
// mux_pipe_if: input and output handshake bundle for mux_pipe.
// The slave modport is the mux_pipe view. The master modport is the view of
// whoever drives the inputs and consumes the outputs.
interface mux_pipe_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 2,
  parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]          in_sel;
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/mux_pipe.sv
// mux_pipe: CHANNELS-to-1 channel mux followed by a 2-entry FIFO.
// The FIFO holds the selected data and the select value that produced it.
// Optional macro MUX_PIPE_SELCHK_EN adds two outputs for out-of-range
// selects: a sticky sel_err flag and sel_err_cnt, a saturating 8-bit count.
module mux_pipe #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 2,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic       clk,
  input  logic       rst_n,
  mux_pipe_if.slave  bus
`ifdef MUX_PIPE_SELCHK_EN
  ,
  output logic       sel_err,
  output logic [7:0] sel_err_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

  occ_e             r_state;
  occ_e             w_state_nxt;
  logic [WIDTH-1:0] r_mem_data [2];
  logic [SEL_W-1:0] r_mem_sel  [2];
  logic             r_wptr;
  logic             r_rptr;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_sel_data;

  // The handshake flags decode the registered occupancy only.
  // As a result, in_ready never depends combinationally on out_ready.
  assign w_in_ready  = (r_state != ST_FULL);
  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_mem_data[r_rptr];
  assign bus.out_sel   = r_mem_sel[r_rptr];

  // Select one channel. A select with no matching channel yields zero data.
  always_comb begin
    // NOTE: the default comes first so every path assigns w_sel_data.
    // Without it, the tool would infer a latch.
    w_sel_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(bus.in_sel) == k) w_sel_data = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  // Next occupancy: a push alone increments it and a pop alone decrements it.
  // A push together with a pop leaves it unchanged.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_push) w_state_nxt = ST_ONE;
      ST_ONE: begin
        if (w_push && !w_pop)      w_state_nxt = ST_FULL;
        else if (!w_push && w_pop) w_state_nxt = ST_EMPTY;
      end
      ST_FULL:  if (w_pop) w_state_nxt = ST_ONE;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments.
    // Every register then samples pre-edge values, whatever the block order.
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Entry storage and 1-bit pointers that wrap from 1 to 0.
  // In the ONE state, a same-edge push and pop writes the free slot and
  // advances the read pointer onto the entry just written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset on purpose so that out_data and out_sel
      // read zero straight out of reset. At two entries this costs little.
      r_mem_data[0] <= '0;
      r_mem_data[1] <= '0;
      r_mem_sel[0]  <= '0;
      r_mem_sel[1]  <= '0;
      r_wptr        <= 1'b0;
      r_rptr        <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wptr] <= w_sel_data;
        r_mem_sel[r_wptr]  <= bus.in_sel;
        r_wptr             <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
    end
  end

`ifdef MUX_PIPE_SELCHK_EN
  logic       w_sel_bad;
  logic       r_sel_err;
  logic [7:0] r_sel_err_cnt;

  assign w_sel_bad   = (int'(bus.in_sel) >= CHANNELS);
  assign sel_err     = r_sel_err;
  assign sel_err_cnt = r_sel_err_cnt;

  // Sticky flag and saturating count of accepted out-of-range selects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err     <= 1'b0;
      r_sel_err_cnt <= 8'd0;
    end else if (w_push && w_sel_bad) begin
      r_sel_err <= 1'b1;
      if (r_sel_err_cnt != 8'hFF) r_sel_err_cnt <= r_sel_err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_pipe.sv
// tb_mux_pipe: directed and table-driven bench for mux_pipe.
// It drives four instances, each in its own configuration:
//   a: WIDTH=1,  CHANNELS=2
//   b: WIDTH=8,  CHANNELS=4
//   c: WIDTH=8,  CHANNELS=3
//   d: WIDTH=16, CHANNELS=16
module tb_mux_pipe;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  mux_pipe_if #(.WIDTH(1),  .CHANNELS(2))  if_a ();
  mux_pipe_if #(.WIDTH(8),  .CHANNELS(4))  if_b ();
  mux_pipe_if #(.WIDTH(8),  .CHANNELS(3))  if_c ();
  mux_pipe_if #(.WIDTH(16), .CHANNELS(16)) if_d ();

`ifdef MUX_PIPE_SELCHK_EN
  logic       se_a, se_b, se_c, se_d;
  logic [7:0] sc_a, sc_b, sc_c, sc_d;
`endif

  mux_pipe #(.WIDTH(1), .CHANNELS(2)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a)
`ifdef MUX_PIPE_SELCHK_EN
    , .sel_err(se_a), .sel_err_cnt(sc_a)
`endif
  );
  mux_pipe #(.WIDTH(8), .CHANNELS(4)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b)
`ifdef MUX_PIPE_SELCHK_EN
    , .sel_err(se_b), .sel_err_cnt(sc_b)
`endif
  );
  mux_pipe #(.WIDTH(8), .CHANNELS(3)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c)
`ifdef MUX_PIPE_SELCHK_EN
    , .sel_err(se_c), .sel_err_cnt(sc_c)
`endif
  );
  mux_pipe #(.WIDTH(16), .CHANNELS(16)) u_d (
    .clk(clk), .rst_n(rst_n), .bus(if_d)
`ifdef MUX_PIPE_SELCHK_EN
    , .sel_err(se_d), .sel_err_cnt(sc_d)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic ch0;
    logic ch1;
    logic sel;
    logic exp;
  } vec_t;

  typedef struct packed {
    logic [3:0]  sel;
    logic [15:0] data;
  } ent_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  // Inputs are driven and outputs sampled at that point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vt [8];
    ent_t q [$];
    ent_t e;
    logic [3:0] rs;

    n_vec = 0;
    n_err = 0;

    // Truth table: out = sel ? ch1 : ch0.
    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vt[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
    vt[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    vt[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vt[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
    vt[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

    if_a.in_data = '0; if_a.in_sel = '0; if_a.in_valid = 0; if_a.out_ready = 0;
    if_b.in_data = '0; if_b.in_sel = '0; if_b.in_valid = 0; if_b.out_ready = 0;
    if_c.in_data = '0; if_c.in_sel = '0; if_c.in_valid = 0; if_c.out_ready = 0;
    if_d.in_data = '0; if_d.in_sel = '0; if_d.in_valid = 0; if_d.out_ready = 0;

    rst_n = 1'b0;
    step();
    step();
    check("rst_out_valid", 64'(if_a.out_valid), 64'd0);
    check("rst_in_ready",  64'(if_a.in_ready),  64'd1);
    check("rst_out_data",  64'(if_a.out_data),  64'd0);
    check("rst_out_sel",   64'(if_a.out_sel),   64'd0);
    rst_n = 1'b1;
    step();

    // Back-to-back transfers with out_ready high: each edge does a push and a pop.
    if_a.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if_a.in_data  = {vt[i].ch1, vt[i].ch0};
      if_a.in_sel   = vt[i].sel;
      if_a.in_valid = 1'b1;
      step();
      check($sformatf("tt%0d_valid", i), 64'(if_a.out_valid), 64'd1);
      check($sformatf("tt%0d_data",  i), 64'(if_a.out_data),  64'(vt[i].exp));
      check($sformatf("tt%0d_sel",   i), 64'(if_a.out_sel),   64'(vt[i].sel));
    end
    if_a.in_valid = 1'b0;
    step();
    check("tt_drain_valid", 64'(if_a.out_valid), 64'd0);

    // Fill to FULL, hold the output, ignore a push into FULL, then drain in order.
    if_b.out_ready = 1'b0;
    if_b.in_data   = 32'h44_33_A1_11;
    if_b.in_sel    = 2'd1;
    if_b.in_valid  = 1'b1;
    step();
    check("full_p1_valid", 64'(if_b.out_valid), 64'd1);
    check("full_p1_data",  64'(if_b.out_data),  64'hA1);
    check("full_p1_ready", 64'(if_b.in_ready),  64'd1);
    if_b.in_data = 32'h55_B2_66_77;
    if_b.in_sel  = 2'd2;
    step();
    check("full_p2_ready", 64'(if_b.in_ready), 64'd0);
    check("full_p2_data",  64'(if_b.out_data), 64'hA1);
    if_b.in_data = 32'h00_00_00_EE;
    if_b.in_sel  = 2'd0;
    step();
    check("full_hold_data",  64'(if_b.out_data), 64'hA1);
    check("full_hold_sel",   64'(if_b.out_sel),  64'd1);
    check("full_hold_ready", 64'(if_b.in_ready), 64'd0);
    if_b.in_valid  = 1'b0;
    if_b.out_ready = 1'b1;
    step();
    check("drain1_data",  64'(if_b.out_data),  64'hB2);
    check("drain1_sel",   64'(if_b.out_sel),   64'd2);
    check("drain1_ready", 64'(if_b.in_ready),  64'd1);
    check("drain1_valid", 64'(if_b.out_valid), 64'd1);
    step();
    check("drain2_valid", 64'(if_b.out_valid), 64'd0);

    // In ONE, a push with a simultaneous pop replaces the popped entry.
    if_b.out_ready = 1'b0;
    if_b.in_data   = 32'h00_00_00_5A;
    if_b.in_sel    = 2'd0;
    if_b.in_valid  = 1'b1;
    step();
    check("one_pre_data", 64'(if_b.out_data), 64'h5A);
    if_b.in_data   = 32'hC3_00_00_00;
    if_b.in_sel    = 2'd3;
    if_b.out_ready = 1'b1;
    step();
    check("one_pp_data",  64'(if_b.out_data),  64'hC3);
    check("one_pp_sel",   64'(if_b.out_sel),   64'd3);
    check("one_pp_ready", 64'(if_b.in_ready),  64'd1);
    if_b.in_valid = 1'b0;
    step();
    check("one_pp_empty", 64'(if_b.out_valid), 64'd0);

    // Out-of-range select on CHANNELS=3 gives zero data and keeps the select.
`ifdef MUX_PIPE_SELCHK_EN
    check("selchk_pre_err", 64'(se_c), 64'd0);
`endif
    if_c.out_ready = 1'b0;
    if_c.in_data   = 24'hCC_BB_AA;
    if_c.in_sel    = 2'd3;
    if_c.in_valid  = 1'b1;
    step();
    check("bad_sel_valid", 64'(if_c.out_valid), 64'd1);
    check("bad_sel_data",  64'(if_c.out_data),  64'd0);
    check("bad_sel_sel",   64'(if_c.out_sel),   64'd3);
`ifdef MUX_PIPE_SELCHK_EN
    check("selchk_err", 64'(se_c), 64'd1);
    check("selchk_cnt", 64'(sc_c), 64'd1);
`endif
    if_c.in_sel    = 2'd1;
    if_c.out_ready = 1'b1;
    step();
    check("c_legal_data", 64'(if_c.out_data), 64'hBB);
    check("c_legal_sel",  64'(if_c.out_sel),  64'd1);
`ifdef MUX_PIPE_SELCHK_EN
    check("selchk_sticky", 64'(se_c), 64'd1);
    check("selchk_cnt2",   64'(sc_c), 64'd1);
`endif
    if_c.in_valid = 1'b0;
    step();

    // Asynchronous reset between edges while FULL.
    if_b.out_ready = 1'b0;
    if_b.in_data   = 32'h11_22_33_44;
    if_b.in_sel    = 2'd0;
    if_b.in_valid  = 1'b1;
    step();
    step();
    if_b.in_valid = 1'b0;
    check("arst_pre_ready", 64'(if_b.in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(if_b.out_valid), 64'd0);
    check("arst_ready", 64'(if_b.in_ready),  64'd1);
    check("arst_data",  64'(if_b.out_data),  64'd0);
`ifdef MUX_PIPE_SELCHK_EN
    check("arst_selerr", 64'(se_c), 64'd0);
`endif
    #2 rst_n = 1'b1;
    step();
    check("post_rst_idle", 64'(if_b.out_valid), 64'd0);
    if_b.in_data  = 32'h00_00_00_3C;
    if_b.in_sel   = 2'd0;
    if_b.in_valid = 1'b1;
    step();
    if_b.in_valid = 1'b0;
    check("post_rst_valid", 64'(if_b.out_valid), 64'd1);
    check("post_rst_data",  64'(if_b.out_data),  64'h3C);
    if_b.out_ready = 1'b1;
    step();
    if_b.out_ready = 1'b0;

    // Random handshakes on the wide instance, compared against a reference queue.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      check("rnd_out_valid", 64'(if_d.out_valid), 64'(q.size() != 0));
      check("rnd_in_ready",  64'(if_d.in_ready),  64'(q.size() < 2));
      for (int w = 0; w < 8; w++) if_d.in_data[w*32 +: 32] = $urandom;
      rs             = 4'($urandom_range(0, 15));
      if_d.in_sel    = rs;
      if_d.in_valid  = 1'($urandom_range(0, 1));
      if_d.out_ready = ($urandom_range(0, 3) != 0);
      if (if_d.out_valid && if_d.out_ready && q.size() != 0) begin
        e = q.pop_front();
        check("rnd_data", 64'(if_d.out_data), 64'(e.data));
        check("rnd_sel",  64'(if_d.out_sel),  64'(e.sel));
      end
      if (if_d.in_valid && if_d.in_ready) begin
        e.sel  = rs;
        e.data = if_d.in_data[int'(rs)*16 +: 16];
        q.push_back(e);
      end
      step();
    end
    if_d.in_valid  = 1'b0;
    if_d.out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_pipe.md
MUX_PIPE -- requirements
Module: mux_pipe

Interface
REQ-001 Parameter WIDTH, default 1, bits per channel; legal range 1..64.
REQ-002 Parameter CHANNELS, default 2, number of input channels; legal range 2..16.
REQ-003 Derived SEL_W = max(1, ceil(log2(CHANNELS))).
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_data  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 in_sel  input  SEL_W  channel select for the current transfer.
REQ-008 in_valid  input  1  in_data/in_sel are valid.
REQ-009 in_ready  output  1  block can accept a transfer.
REQ-010 out_data  output  WIDTH  selected channel data.
REQ-011 out_sel  output  SEL_W  select value that produced out_data.
REQ-012 out_valid  output  1  out_data/out_sel are valid.
REQ-013 out_ready  input  1  consumer accepts the output.

Function
REQ-014 Input transfer occurs on a clk edge where in_valid=1 and in_ready=1; output transfer occurs where out_valid=1 and out_ready=1.
REQ-015 At transfer, the block captures in_data[in_sel*WIDTH +: WIDTH] and in_sel into a 2-entry FIFO; for WIDTH=1 and CHANNELS=2 this is z = (sel & ch1) | (~sel & ch0).
REQ-016 in_sel >= CHANNELS (non-power-of-two CHANNELS) selects all-zero data.
REQ-017 Latency: data accepted at edge N appears on out_data with out_valid=1 after edge N when the FIFO was empty.
REQ-018 FIFO occupancy states EMPTY(0), ONE(1), FULL(2); push-only increments, pop-only decrements, push+pop keeps occupancy.
REQ-019 in_ready = 1 in EMPTY and ONE, 0 in FULL; in_ready does not depend combinationally on out_ready.
REQ-020 out_valid = 1 in ONE and FULL; out_data/out_sel always show the oldest entry.
REQ-021 Simultaneous push and pop in ONE: the popped entry is replaced by the pushed entry in the same edge; order is strictly FIFO.
REQ-022 Output held stable (data and sel) while out_valid=1 and out_ready=0.
REQ-023 Read and write pointers are 1 bit each and wrap 1->0.
REQ-024 in_valid without in_ready, and out_ready without out_valid, have no effect.

Reset
REQ-025 rst_n=0 asynchronously forces occupancy EMPTY, pointers 0, out_valid=0, in_ready=1, out_data=0, out_sel=0.
REQ-026 Reset mid-operation discards all buffered entries; first transfer after release behaves per REQ-017.
REQ-027 Reset deassertion is taken on the next clk edge; no transfer occurs on the edge where rst_n rises.

Configuration
REQ-028 Macro MUX_PIPE_SELCHK_EN: when defined, a sticky output sel_err (1 bit, reset 0) sets on any input transfer with in_sel >= CHANNELS and clears only on reset.
REQ-029 With MUX_PIPE_SELCHK_EN defined, an 8-bit saturating counter sel_err_cnt (reset 0) counts such transfers, holding at 255.
REQ-030 Without MUX_PIPE_SELCHK_EN, sel_err and sel_err_cnt ports do not exist; all other behaviour is identical.

Verification
REQ-031 WIDTH=1, CHANNELS=2, all 8 (ch0,ch1,sel) combinations with out_ready=1 -> out_data = sel?ch1:ch0 one edge after each transfer, 8/8 PASS.
REQ-032 WIDTH=8, CHANNELS=4, out_ready=0, push 0xA1 (sel 1) and 0xB2 (sel 2) -> in_ready=0 after second push; raise out_ready -> 0xA1 then 0xB2 out, in order.
REQ-033 ONE state, push 0xC3 with concurrent pop -> popped entry leaves, 0xC3 is next output, occupancy stays ONE, no data lost.
REQ-034 CHANNELS=3, in_sel=3 transfer -> out_data=0, out_sel=3; with MUX_PIPE_SELCHK_EN sel_err=1 and sel_err_cnt=1.
REQ-035 FULL state, pulse rst_n=0 between edges -> out_valid=0 and in_ready=1 immediately, before next edge; subsequent push yields output after one edge.
REQ-036 Random in_valid/out_ready over 10000 cycles, WIDTH=16, CHANNELS=16 -> output stream matches a reference queue of selected values exactly.
